throw_launcher: RTL and testbench

//  Local initiator of a throw for the hit/HP simulation stage. Converts a held throw button into a

---
 rtl/variable_pkg.sv | 27 ++
 rtl/throw_launcher_if.sv | 24 ++
 rtl/trajectory_step.sv | 59 +++++
 rtl/throw_launcher.sv | 143 ++++++++++++++
 tb/tb_throw_launcher.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/variable_pkg.sv
// rtl/variable_pkg.sv - shared player ids, launcher constants and launcher state enum
package variable_pkg;

  localparam logic [1:0]  PLAYER_1      = 2'd1;
  localparam logic [1:0]  PLAYER_2      = 2'd2;

  localparam logic [11:0] Y_START       = 12'd300;
  localparam logic [11:0] Y_GROUND      = 12'd472;
  localparam logic [11:0] Y_IDLE        = 12'd768;
  localparam logic [7:0]  VY0           = 8'd12;
  localparam logic [7:0]  GRAVITY       = 8'd1;
  localparam logic [4:0]  SPEED_MIN     = 5'd4;
  localparam logic [4:0]  SPEED_MAX     = 5'd31;
  localparam int          TIMEOUT_TICKS = 400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    FLIGHT = 2'd2
  } launcher_state_t;

  // The local station may throw only when its role matches the current turn.
  function automatic logic my_turn_f(input logic [1:0] player, input logic turn);
    return ((player == PLAYER_1) && !turn) || ((player == PLAYER_2) && turn);
  endfunction

endpackage

// File: rtl/throw_launcher_if.sv
// rtl/throw_launcher_if.sv - button/simulation handshake bundle of the throw launcher
interface throw_launcher_if;

  logic        btn_throw;
  logic [1:0]  current_player;
  logic        turn;
  logic        end_throw;
  logic        throw_flag;
  logic [4:0]  speed;
  logic [11:0] ypos_prebuff;
  logic        busy;
  logic        timeout;

  modport master (
    input  btn_throw, current_player, turn, end_throw,
    output throw_flag, speed, ypos_prebuff, busy, timeout
  );

  modport slave (
    output btn_throw, current_player, turn, end_throw,
    input  throw_flag, speed, ypos_prebuff, busy, timeout
  );

endinterface

// File: rtl/trajectory_step.sv
// rtl/trajectory_step.sv - registered vertical position/velocity update with saturation
module trajectory_step
  import variable_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic        tick,
  output logic [11:0] ypos_o
);

  logic [11:0]        ypos_q, ypos_d;
  logic signed [7:0]  vy_q, vy_d;
  logic signed [12:0] ysum;
  logic signed [8:0]  vsum;

  // Next position/velocity: clear beats load beats a trajectory tick.
  always_comb begin
    ypos_d = ypos_q;
    vy_d   = vy_q;
    ysum   = $signed({1'b0, ypos_q}) + $signed({{5{vy_q[7]}}, vy_q});
    vsum   = $signed({vy_q[7], vy_q}) + $signed({1'b0, GRAVITY});
    if (clear) begin
      ypos_d = Y_IDLE;
      vy_d   = 8'sd0;
    end else if (load) begin
      ypos_d = Y_START;
      vy_d   = $signed(8'd0 - VY0);
    end else if (tick) begin
      if (ysum < 13'sd0) begin
        ypos_d = 12'd0;
      end else if (ysum > $signed({1'b0, Y_GROUND})) begin
        ypos_d = Y_GROUND;
      end else begin
        ypos_d = ysum[11:0];
      end
      if (vsum > 9'sd127) begin
        vy_d = 8'sd127;
      end else begin
        vy_d = vsum[7:0];
      end
    end
  end

  // Trajectory state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ypos_q <= Y_IDLE;
      vy_q   <= 8'sd0;
    end else begin
      ypos_q <= ypos_d;
      vy_q   <= vy_d;
    end
  end

  assign ypos_o = ypos_q;

endmodule

// File: rtl/throw_launcher.sv
// rtl/throw_launcher.sv - charge/launch/flight FSM for a local throw; THROW_TIMEOUT_EN adds a flight watchdog
module throw_launcher
  import variable_pkg::*;
#(
  parameter int TICK_CYCLES   = 250000,
  parameter int CHARGE_CYCLES = 3000000
) (
  input  logic               clk60MHz,
  input  logic               rst_n,
  throw_launcher_if.master   bus
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int CW = $clog2(CHARGE_CYCLES + 1);

  launcher_state_t state_q;
  logic [4:0]      speed_q;
  logic            busy_q;
  logic            flag_q;
  logic            btn_q;
  logic [CW-1:0]   charge_cnt_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [11:0]     ypos;

  logic my_turn, btn_rise, charge_wrap, tick, expire, load, clear;

  assign my_turn     = my_turn_f(bus.current_player, bus.turn);
  assign btn_rise    = bus.btn_throw && !btn_q;
  assign charge_wrap = (charge_cnt_q == CW'(CHARGE_CYCLES - 1));
  assign tick        = (state_q == FLIGHT) && (tick_cnt_q == TW'(TICK_CYCLES - 1));
  assign load        = (state_q == CHARGE) && my_turn && !bus.btn_throw;
  assign clear       = (state_q == FLIGHT) && (bus.end_throw || expire);

`ifdef THROW_TIMEOUT_EN
  localparam int NW = $clog2(TIMEOUT_TICKS + 1);
  logic [NW-1:0] tick_num_q;
  logic          timeout_q;

  assign expire = tick && (tick_num_q == NW'(TIMEOUT_TICKS - 1));

  // Flight watchdog: counts trajectory ticks since launch, pulses on expiry.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      tick_num_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= expire && !bus.end_throw;
      if (load) begin
        tick_num_q <= '0;
      end else if (tick) begin
        tick_num_q <= tick_num_q + 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Button edge register: only a fresh press in IDLE starts a charge.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= bus.btn_throw;
    end
  end

  // Launcher FSM with charge counter, tick divider and registered outputs.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      speed_q      <= 5'd0;
      busy_q       <= 1'b0;
      flag_q       <= 1'b0;
      charge_cnt_q <= '0;
      tick_cnt_q   <= '0;
    end else begin
      flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_rise && my_turn) begin
            state_q      <= CHARGE;
            speed_q      <= SPEED_MIN;
            charge_cnt_q <= '0;
            busy_q       <= 1'b1;
          end
        end
        CHARGE: begin
          if (!my_turn) begin
            state_q <= IDLE;
            speed_q <= 5'd0;
            busy_q  <= 1'b0;
          end else if (!bus.btn_throw) begin
            state_q    <= FLIGHT;
            flag_q     <= 1'b1;
            tick_cnt_q <= '0;
          end else if (charge_wrap) begin
            charge_cnt_q <= '0;
            if (speed_q != SPEED_MAX) begin
              speed_q <= speed_q + 5'd1;
            end
          end else begin
            charge_cnt_q <= charge_cnt_q + 1'b1;
          end
        end
        FLIGHT: begin
          if (bus.end_throw || expire) begin
            state_q <= IDLE;
            speed_q <= 5'd0;
            busy_q  <= 1'b0;
          end else if (tick) begin
            tick_cnt_q <= '0;
          end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          speed_q <= 5'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  trajectory_step u_traj (
    .clk    (clk60MHz),
    .rst_n  (rst_n),
    .clear  (clear),
    .load   (load),
    .tick   (tick && !bus.end_throw),
    .ypos_o (ypos)
  );

  assign bus.throw_flag   = flag_q;
  assign bus.speed        = speed_q;
  assign bus.busy         = busy_q;
  assign bus.ypos_prebuff = ypos;

endmodule

// File: tb/tb_throw_launcher.sv
// tb/tb_throw_launcher.sv - directed self-checking bench for throw_launcher
module tb_throw_launcher;
  import variable_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  throw_launcher_if bus();

  throw_launcher #(
    .TICK_CYCLES   (4),
    .CHARGE_CYCLES (8)
  ) dut (
    .clk60MHz (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_throw = 1'b0;
    bus.current_player = PLAYER_1;
    bus.turn = 1'b0;
    bus.end_throw = 1'b0;
    repeat (3) step();
    checks++; if (bus.throw_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %0b want 0", bus.throw_flag); end
    checks++; if (bus.speed !== 5'd0) begin errors++; $display("FAIL reset_speed got %0d want 0", bus.speed); end
    checks++; if (bus.ypos_prebuff !== 12'd768) begin errors++; $display("FAIL reset_ypos got %0d want 768", bus.ypos_prebuff); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", bus.timeout); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_charge_and_flight();
    int flags;
    bus.current_player = PLAYER_1;
    bus.turn = 1'b0;
    bus.btn_throw = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b1 || bus.speed !== 5'd4) begin errors++; $display("FAIL press_charge busy %0b speed %0d want 1/4", bus.busy, bus.speed); end
    repeat (19) step();
    bus.btn_throw = 1'b0;
    step();
    checks++; if (bus.throw_flag !== 1'b1) begin errors++; $display("FAIL launch_flag got %0b want 1", bus.throw_flag); end
    checks++; if (bus.speed !== 5'd6) begin errors++; $display("FAIL launch_speed got %0d want 6", bus.speed); end
    checks++; if (bus.ypos_prebuff !== 12'd300) begin errors++; $display("FAIL launch_ypos got %0d want 300", bus.ypos_prebuff); end
    step();
    checks++; if (bus.throw_flag !== 1'b0) begin errors++; $display("FAIL flag_single got %0b want 0", bus.throw_flag); end
    step(); step();
    checks++; if (bus.ypos_prebuff !== 12'd300) begin errors++; $display("FAIL pre_tick_ypos got %0d want 300", bus.ypos_prebuff); end
    step();
    checks++; if (bus.ypos_prebuff !== 12'd288) begin errors++; $display("FAIL tick1_ypos got %0d want 288", bus.ypos_prebuff); end
    repeat (4) step();
    checks++; if (bus.ypos_prebuff !== 12'd277) begin errors++; $display("FAIL tick2_ypos got %0d want 277", bus.ypos_prebuff); end
    repeat (4) step();
    checks++; if (bus.ypos_prebuff !== 12'd267) begin errors++; $display("FAIL tick3_ypos got %0d want 267", bus.ypos_prebuff); end
    flags = 0;
    for (int i = 0; i < 160; i++) begin
      bus.btn_throw = (i >= 50 && i < 60);
      step();
      if (bus.throw_flag === 1'b1) flags++;
    end
    checks++; if (flags != 0) begin errors++; $display("FAIL flight_btn_ignored flags %0d want 0", flags); end
    checks++; if (bus.ypos_prebuff !== 12'd472 || bus.busy !== 1'b1) begin errors++; $display("FAIL ground_hold ypos %0d busy %0b want 472/1", bus.ypos_prebuff, bus.busy); end
    repeat (4) step();
    checks++; if (bus.ypos_prebuff !== 12'd472) begin errors++; $display("FAIL ground_stay ypos %0d want 472", bus.ypos_prebuff); end
    bus.end_throw = 1'b1;
    step();
    bus.end_throw = 1'b0;
    checks++; if (bus.ypos_prebuff !== 12'd768 || bus.busy !== 1'b0 || bus.speed !== 5'd0) begin errors++; $display("FAIL end_throw ypos %0d busy %0b speed %0d want 768/0/0", bus.ypos_prebuff, bus.busy, bus.speed); end
    step();
  endtask

  task automatic test_turn_rules();
    bus.current_player = PLAYER_2;
    bus.turn = 1'b0;
    bus.btn_throw = 1'b1;
    step();
    repeat (5) step();
    checks++; if (bus.busy !== 1'b0 || bus.speed !== 5'd0 || bus.throw_flag !== 1'b0) begin errors++; $display("FAIL not_my_turn busy %0b speed %0d flag %0b want 0/0/0", bus.busy, bus.speed, bus.throw_flag); end
    bus.btn_throw = 1'b0;
    step();
    bus.end_throw = 1'b1;
    step();
    bus.end_throw = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.ypos_prebuff !== 12'd768) begin errors++; $display("FAIL end_throw_idle busy %0b ypos %0d want 0/768", bus.busy, bus.ypos_prebuff); end
    bus.turn = 1'b1;
    bus.btn_throw = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b1 || bus.speed !== 5'd4) begin errors++; $display("FAIL p2_press busy %0b speed %0d want 1/4", bus.busy, bus.speed); end
    bus.end_throw = 1'b1;
    step();
    bus.end_throw = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL end_throw_charge busy %0b want 1", bus.busy); end
    repeat (320) step();
    checks++; if (bus.speed !== 5'd31) begin errors++; $display("FAIL speed_cap got %0d want 31", bus.speed); end
    bus.turn = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.speed !== 5'd0 || bus.throw_flag !== 1'b0) begin errors++; $display("FAIL turn_drop busy %0b speed %0d flag %0b want 0/0/0", bus.busy, bus.speed, bus.throw_flag); end
    bus.btn_throw = 1'b0;
    step();
    checks++; if (bus.throw_flag !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL turn_drop_release flag %0b busy %0b want 0/0", bus.throw_flag, bus.busy); end
  endtask

  task automatic test_end_throw_on_tick();
    bus.current_player = PLAYER_1;
    bus.turn = 1'b0;
    bus.btn_throw = 1'b1;
    step();
    bus.btn_throw = 1'b0;
    step();
    checks++; if (bus.throw_flag !== 1'b1 || bus.speed !== 5'd4) begin errors++; $display("FAIL quick_launch flag %0b speed %0d want 1/4", bus.throw_flag, bus.speed); end
    repeat (3) step();
    bus.end_throw = 1'b1;
    step();
    bus.end_throw = 1'b0;
    checks++; if (bus.ypos_prebuff !== 12'd768 || bus.busy !== 1'b0) begin errors++; $display("FAIL end_on_tick ypos %0d busy %0b want 768/0", bus.ypos_prebuff, bus.busy); end
    repeat (4) step();
    checks++; if (bus.ypos_prebuff !== 12'd768) begin errors++; $display("FAIL end_on_tick_hold ypos %0d want 768", bus.ypos_prebuff); end
  endtask

  task automatic test_reset_mid_flight();
    int flags;
    bus.btn_throw = 1'b1;
    step();
    bus.btn_throw = 1'b0;
    step();
    repeat (6) step();
    checks++; if (bus.ypos_prebuff !== 12'd288 || bus.busy !== 1'b1) begin errors++; $display("FAIL mid_flight ypos %0d busy %0b want 288/1", bus.ypos_prebuff, bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ypos_prebuff !== 12'd768 || bus.busy !== 1'b0 || bus.speed !== 5'd0) begin errors++; $display("FAIL async_reset ypos %0d busy %0b speed %0d want 768/0/0", bus.ypos_prebuff, bus.busy, bus.speed); end
    repeat (3) step();
    rst_n = 1'b1;
    flags = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.throw_flag === 1'b1) flags++;
    end
    checks++; if (flags != 0 || bus.ypos_prebuff !== 12'd768 || bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset flags %0d ypos %0d busy %0b want 0/768/0", flags, bus.ypos_prebuff, bus.busy); end
  endtask

  task automatic test_timeout();
    int pulses;
    int at;
    bus.btn_throw = 1'b1;
    step();
    bus.btn_throw = 1'b0;
    step();
    pulses = 0;
    at = -1;
    for (int i = 1; i <= 1610; i++) begin
      step();
      if (bus.timeout === 1'b1) begin
        pulses++;
        if (at < 0) at = i;
      end
    end
`ifdef THROW_TIMEOUT_EN
    checks++; if (pulses != 1 || at != 1600) begin errors++; $display("FAIL timeout_pulse count %0d at %0d want 1 at 1600", pulses, at); end
    checks++; if (bus.busy !== 1'b0 || bus.ypos_prebuff !== 12'd768 || bus.speed !== 5'd0) begin errors++; $display("FAIL timeout_idle busy %0b ypos %0d speed %0d want 0/768/0", bus.busy, bus.ypos_prebuff, bus.speed); end
`else
    checks++; if (pulses != 0) begin errors++; $display("FAIL no_timeout count %0d want 0", pulses); end
    checks++; if (bus.busy !== 1'b1 || bus.ypos_prebuff !== 12'd472) begin errors++; $display("FAIL stay_flight busy %0b ypos %0d want 1/472", bus.busy, bus.ypos_prebuff); end
`endif
    bus.end_throw = 1'b1;
    step();
    bus.end_throw = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.ypos_prebuff !== 12'd768) begin errors++; $display("FAIL final_idle busy %0b ypos %0d want 0/768", bus.busy, bus.ypos_prebuff); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_charge_and_flight();
    test_turn_rules();
    test_end_throw_on_tick();
    test_reset_mid_flight();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
